mem_port_arbiter: RTL and testbench

- Shares one external single-port memory bus between the Fetch stage (instruction reads) and the Memory stage (data reads/writes) of the pipelined core.
- Contains the grant FSM, a fairness counter that prevents starvation, and a wait-timeout watchdog.
- Drives stall requests back to the pipeline while each requester waits.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-bus signals shared by the fetch stage, the
// memory stage, the external memory and the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              err_timeout;

    // arbiter side: owns the memory bus and answers both pipeline requesters
    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, err_timeout
    );

    // environment side: pipeline requesters plus the external memory
    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, err_timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data
// access. Data wins ties, a run counter bounds consecutive data grants while
// fetch waits, and a watchdog aborts accesses the memory never acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DM_RUN = 2,
    parameter int TIMEOUT    = 64
) (
    input logic            clock,
    input logic            reset,
    mem_port_arbiter_if.master bus
);
    localparam int RUN_W  = $clog2(MAX_DM_RUN + 1);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_DM_RUN);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;

    state_t            state, state_nx;
    logic [RUN_W-1:0]  run, run_nx;
    logic [WAIT_W-1:0] wcnt;
    logic              busy, ack, expire, done;

    // mem_req is high exactly while an access is in flight, so an ack seen
    // with mem_req low (idle, response cycle, after reset) never counts
    assign busy   = (state == IF_BUSY) || (state == DM_BUSY);
    assign ack    = busy && bus.mem_req && bus.mem_ack;
    assign expire = busy && !ack && (wcnt == WAIT_LAST);
    assign done   = ack || expire;

    assign bus.stall_if  = bus.if_req & ~bus.if_valid;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_valid;

    // next state and run counter: data first unless fetch has waited too long
    always_comb begin
        state_nx = state;
        run_nx   = run;
        case (state)
            IDLE: begin
                if (bus.dm_req && (!bus.if_req || run < RUN_MAX)) begin
                    state_nx = DM_BUSY;
                    if (run != RUN_MAX) run_nx = run + RUN_W'(1);
                end else if (bus.if_req) begin
                    state_nx = IF_BUSY;
                    run_nx   = '0;
                end else begin
                    run_nx = '0;
                end
            end
            IF_BUSY, DM_BUSY: if (done) state_nx = RESP;
            RESP:             state_nx = IDLE;
            default:          state_nx = IDLE;
        endcase
    end

    // state and run counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            run   <= '0;
        end else begin
            state <= state_nx;
            run   <= run_nx;
        end
    end

    // wait counter: zero outside an access, counts busy cycles without ack
    always_ff @(posedge clock) begin
        if (reset || !busy) wcnt <= '0;
        else if (!ack)      wcnt <= wcnt + WAIT_W'(1);
    end

    // bus request registers: loaded on grant, held until completion
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (state == IDLE) begin
            if (state_nx == DM_BUSY) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= bus.dm_we;
                bus.mem_addr  <= bus.dm_addr;
                bus.mem_wdata <= bus.dm_wdata;
            end else if (state_nx == IF_BUSY) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= 1'b0;
                bus.mem_addr  <= bus.if_addr;
                bus.mem_wdata <= '0;
            end
        end else if (done) begin
            bus.mem_req <= 1'b0;
        end
    end

    // completion pulses and returned data; aborts and writes return zero
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.if_valid    <= 1'b0;
            bus.dm_valid    <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.if_rdata    <= '0;
            bus.dm_rdata    <= '0;
        end else begin
            bus.if_valid    <= (state == IF_BUSY) && done;
            bus.dm_valid    <= (state == DM_BUSY) && done;
            bus.err_timeout <= expire;
            if ((state == IF_BUSY) && done)
                bus.if_rdata <= ack ? bus.mem_rdata : '0;
            if ((state == DM_BUSY) && done)
                bus.dm_rdata <= (ack && !bus.mem_we) ? bus.mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a
// transaction-level reference model that also plays the external memory.
module tb_mem_port_arbiter;
    localparam int TOUT   = 8;
    localparam int MAXRUN = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DM_RUN(MAXRUN), .TIMEOUT(TOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    typedef enum {M_IDLE, M_BUSY, M_RESP} mph_t;

    int checks   = 0;
    int failures = 0;

    // reference model / memory responder state
    mph_t        ph = M_IDLE;
    int          run_m = 0;
    bit          own_dm = 1'b0;
    logic [31:0] g_addr, g_wdata;
    logic        g_we;
    logic [31:0] exp_data;
    bit          exp_err;
    int          busy_n = 0;
    int          ack_dly = 0;
    bit          rand_dly = 1'b0;
    bit          fix_rd = 1'b0;
    logic [31:0] fix_rdata = '0;
    int          idle_ack_mode = 0;
    int          cyc_n = 0;
    bit          done_if, done_dm;
    int          valid_log[$];
    int          req_high_cnt = 0;
    int          if_valid_cyc = -1;
    int          err_cyc = -2;
    int          exp_order[6] = '{1, 1, 0, 1, 1, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the DUT outputs at the falling edge against the
    // model, drive the memory response, advance the model, return just after
    // the next rising edge so the caller can change requests.
    task automatic cyc();
        mph_t ph_n;
        bit   exp_ifv, exp_dmv;
        @(negedge clock);
        cyc_n++;
        ph_n    = ph;
        done_if = 1'b0;
        done_dm = 1'b0;
        exp_ifv = (ph == M_RESP) && !own_dm;
        exp_dmv = (ph == M_RESP) && own_dm;
        if (bus.if_valid === 1'b1) begin valid_log.push_back(0); if_valid_cyc = cyc_n; end
        if (bus.dm_valid === 1'b1) valid_log.push_back(1);
        if (bus.err_timeout === 1'b1) err_cyc = cyc_n;
        if (bus.mem_req === 1'b1) req_high_cnt++;
        chk("stall_if", bus.stall_if, bus.if_req & ~exp_ifv);
        chk("stall_mem", bus.stall_mem, bus.dm_req & ~exp_dmv);
        chk("if_valid", bus.if_valid, exp_ifv);
        chk("dm_valid", bus.dm_valid, exp_dmv);
        chk("err_timeout", bus.err_timeout, (ph == M_RESP) && exp_err);
        case (ph)
            M_IDLE: begin
                chk("idle_mem_req", bus.mem_req, 0);
                bus.mem_ack   = (idle_ack_mode == 2) || (idle_ack_mode == 1 && $urandom_range(0, 2) == 0);
                bus.mem_rdata = $urandom;
                if (bus.dm_req && (!bus.if_req || run_m < MAXRUN)) begin
                    own_dm = 1'b1; g_addr = bus.dm_addr; g_we = bus.dm_we; g_wdata = bus.dm_wdata;
                    run_m  = (run_m < MAXRUN) ? run_m + 1 : MAXRUN;
                    ph_n   = M_BUSY;
                end else if (bus.if_req) begin
                    own_dm = 1'b0; g_addr = bus.if_addr; g_we = 1'b0; g_wdata = '0;
                    run_m  = 0;
                    ph_n   = M_BUSY;
                end else begin
                    run_m = 0;
                end
                busy_n = 0;
                if (ph_n == M_BUSY && rand_dly) ack_dly = $urandom_range(0, TOUT + 1);
            end
            M_BUSY: begin
                chk("busy_mem_req", bus.mem_req, 1);
                chk("mem_addr", bus.mem_addr, g_addr);
                chk("mem_we", bus.mem_we, g_we);
                chk("mem_wdata", bus.mem_wdata, g_wdata);
                bus.mem_rdata = fix_rd ? fix_rdata : $urandom;
                bus.mem_ack   = (busy_n == ack_dly);
                if (busy_n == ack_dly) begin
                    exp_data = (own_dm && g_we) ? 32'h0 : bus.mem_rdata;
                    exp_err  = 1'b0;
                    ph_n     = M_RESP;
                end else if (busy_n == TOUT - 1) begin
                    exp_data = 32'h0;
                    exp_err  = 1'b1;
                    ph_n     = M_RESP;
                end
                busy_n++;
            end
            default: begin
                chk("resp_mem_req", bus.mem_req, 0);
                if (own_dm) chk("dm_rdata", bus.dm_rdata, exp_data);
                else        chk("if_rdata", bus.if_rdata, exp_data);
                done_dm       = own_dm;
                done_if       = !own_dm;
                bus.mem_ack   = (idle_ack_mode == 2) || (idle_ack_mode == 1 && $urandom_range(0, 2) == 0);
                bus.mem_rdata = $urandom;
                ph_n          = M_IDLE;
            end
        endcase
        if (reset) begin
            ph_n  = M_IDLE;
            run_m = 0;
        end
        ph = ph_n;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!(done_if || done_dm) && k < budget);
        chk({tag, "_completed"}, done_if || done_dm, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int start;
        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;

        // reset state, with a stray ack on the bus
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_dm_valid", bus.dm_valid, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        chk("rst_err", bus.err_timeout, 0);
        reset = 1'b0;
        bus.mem_ack = 1'b0;

        // fetch only, ack on first bus cycle: valid two cycles after req
        bus.if_req = 1; bus.if_addr = 32'h100;
        ack_dly = 0; fix_rd = 1; fix_rdata = 32'h0050_0093;
        start = cyc_n + 1;
        wait_done(20, "fetch");
        chk("fetch_latency", cyc_n - start, 2);
        chk("fetch_rdata_held", bus.if_rdata, 32'h0050_0093);
        bus.if_req = 0;

        // simultaneous requests: data first, fetch stalled throughout
        valid_log.delete();
        bus.if_req = 1; bus.if_addr = 32'h104;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000;
        ack_dly = 1; fix_rdata = 32'h1111_2222;
        for (int k = 0; k < 20 && !done_dm; k++) begin
            cyc();
            chk("simul_stall_if", bus.stall_if, 1);
        end
        bus.dm_req = 0; fix_rdata = 32'h2222_3333;
        wait_done(20, "simul_fetch");
        bus.if_req = 0;
        chk("simul_count", valid_log.size(), 2);
        if (valid_log.size() == 2) begin
            chk("simul_first_dm", valid_log[0], 1);
            chk("simul_second_if", valid_log[1], 0);
        end

        // starvation guard: both held, retargeted after each completion
        valid_log.delete();
        fix_rd = 0; ack_dly = 0;
        bus.if_req = 1; bus.if_addr = 32'h300;
        bus.dm_req = 1; bus.dm_addr = 32'h4000;
        for (int n = 0; n < 6; n++) begin
            wait_done(20, "starve");
            if (done_if) bus.if_addr = bus.if_addr + 4;
            if (done_dm) bus.dm_addr = bus.dm_addr + 8;
        end
        bus.if_req = 0; bus.dm_req = 0;
        chk("starve_count", valid_log.size(), 6);
        for (int n = 0; n < 6 && n < valid_log.size(); n++)
            chk($sformatf("starve_order%0d", n), valid_log[n], exp_order[n]);

        // write, ack after 3 cycles: bus held 4 cycles, write returns zero
        cyc();
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
        ack_dly = 3; req_high_cnt = 0;
        wait_done(20, "write");
        chk("write_req_cycles", req_high_cnt, 4);
        chk("write_dm_rdata", bus.dm_rdata, 0);
        bus.dm_req = 0; bus.dm_we = 0;

        // timeout: no ack, abort after TOUT bus cycles
        cyc();
        bus.if_req = 1; bus.if_addr = 32'h200;
        ack_dly = 100; req_high_cnt = 0;
        wait_done(30, "timeout");
        chk("timeout_req_cycles", req_high_cnt, TOUT);
        chk("timeout_same_cycle", err_cyc, if_valid_cyc);
        chk("timeout_rdata", bus.if_rdata, 0);
        // next fetch acked on the last allowed cycle completes normally
        bus.if_addr = 32'h204; ack_dly = TOUT - 1; fix_rd = 1; fix_rdata = 32'h0BAD_CAFE;
        req_high_cnt = 0; err_cyc = -2;
        wait_done(30, "late_ack");
        chk("late_ack_req_cycles", req_high_cnt, TOUT);
        chk("late_ack_no_err", err_cyc, -2);
        chk("late_ack_rdata", bus.if_rdata, 32'h0BAD_CAFE);
        bus.if_req = 0;

        // reset during a data access; acks after reset are ignored
        cyc();
        valid_log.delete();
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h3000; ack_dly = 100;
        cyc();
        cyc();
        reset = 1'b1; idle_ack_mode = 2;
        cyc();
        reset = 1'b0; bus.dm_req = 0;
        chk("midrst_mem_req", bus.mem_req, 0);
        chk("midrst_if_rdata", bus.if_rdata, 0);
        repeat (4) cyc();
        chk("midrst_no_valid", valid_log.size(), 0);
        idle_ack_mode = 0;
        bus.dm_req = 1; bus.dm_addr = 32'h3004; ack_dly = 1; fix_rdata = 32'h5555_AAAA;
        wait_done(20, "after_rst");
        chk("after_rst_rdata", bus.dm_rdata, 32'h5555_AAAA);
        bus.dm_req = 0;

        // randomized traffic with random ack delays and stray idle acks
        rand_dly = 1; fix_rd = 0; idle_ack_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (done_if || !bus.if_req) begin
                bus.if_req  = 1'($urandom_range(0, 1));
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (done_dm || !bus.dm_req) begin
                bus.dm_req   = 1'($urandom_range(0, 1));
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_addr  = $urandom;
                bus.dm_wdata = $urandom;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
